// File: rtl/hough_bin_accumulator.sv
// Hough r-bin histogram: counts hits per event, then scans every bin once to find the
// peak while clearing it. Optional macro LSF_HOUGH_SAT_FLAG_EN adds the sat_flag output.
module hough_bin_accumulator #(
    parameter int W_bin_number_a = 7,
    parameter int RBINS          = 128,
    parameter int W_COUNT        = 5,
    parameter int MIN_HITS       = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [W_bin_number_a-1:0] r_bin,
    input  logic                      r_bin_vld,
    input  logic                      evt_end,
    output logic                      acc_rdy,
    output logic [W_bin_number_a-1:0] peak_bin,
    output logic [W_COUNT-1:0]        peak_count,
    output logic                      peak_found,
    output logic                      peak_vld
`ifdef LSF_HOUGH_SAT_FLAG_EN
    ,
    output logic                      sat_flag
`endif
);

    localparam int WB = W_bin_number_a;
    localparam logic [WB:0]        LP_RBINS    = (WB + 1)'(RBINS);
    localparam logic [WB-1:0]      LP_LAST_IDX = WB'(RBINS - 1);
    localparam logic [W_COUNT-1:0] LP_CNT_MAX  = '1;
    localparam logic [W_COUNT:0]   LP_MIN_HITS = (W_COUNT + 1)'(MIN_HITS);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t             r_state;
    logic [WB-1:0]      r_scan_idx;
    logic [WB-1:0]      r_best_bin;
    logic [W_COUNT-1:0] r_best_cnt;
    logic [WB-1:0]      r_peak_bin;
    logic [W_COUNT-1:0] r_peak_count;
    logic               r_peak_found;
    logic               r_peak_vld;

    logic                          w_in_range;
    logic                          w_accept_hit;
    logic                          w_scanning;
    logic                          w_last_scan;
    logic [RBINS-1:0][W_COUNT-1:0] w_hist;
    logic [W_COUNT-1:0]            w_scan_cnt;
    logic                          w_scan_gt;
    logic [WB-1:0]                 w_next_best_bin;
    logic [W_COUNT-1:0]            w_next_best_cnt;

    assign w_in_range   = {1'b0, r_bin} < LP_RBINS;
    assign acc_rdy      = rst_n && (r_state == ST_ACCUM);
    assign w_accept_hit = acc_rdy && r_bin_vld && w_in_range;
    assign w_scanning   = (r_state == ST_SCAN);
    assign w_last_scan  = w_scanning && (r_scan_idx == LP_LAST_IDX);

    // Strict greater-than keeps the lowest index on ties.
    assign w_scan_cnt      = w_hist[r_scan_idx];
    assign w_scan_gt       = w_scan_cnt > r_best_cnt;
    assign w_next_best_bin = w_scan_gt ? r_scan_idx : r_best_bin;
    assign w_next_best_cnt = w_scan_gt ? w_scan_cnt : r_best_cnt;

    // One saturating counter per bin; hits and scan never coexist, so no RMW hazard.
    genvar gi;
    generate
        for (gi = 0; gi < RBINS; gi++) begin : g_bin
            localparam logic [WB-1:0] LP_IDX = WB'(gi);
            logic [W_COUNT-1:0] r_count;
            logic               w_hit;
            logic               w_clr;

            assign w_hit = w_accept_hit && (r_bin == LP_IDX) && (r_count != LP_CNT_MAX);
            assign w_clr = w_scanning && (r_scan_idx == LP_IDX);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (w_clr) begin
                    r_count <= '0;
                end else if (w_hit) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign w_hist[gi] = r_count;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_ACCUM;
            r_scan_idx   <= '0;
            r_best_bin   <= '0;
            r_best_cnt   <= '0;
            r_peak_bin   <= '0;
            r_peak_count <= '0;
            r_peak_found <= 1'b0;
            r_peak_vld   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    r_peak_vld <= 1'b0;
                    if (evt_end) begin
                        r_state    <= ST_SCAN;
                        r_scan_idx <= '0;
                        r_best_bin <= '0;
                        r_best_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    r_best_bin <= w_next_best_bin;
                    r_best_cnt <= w_next_best_cnt;
                    if (w_last_scan) begin
                        r_state      <= ST_REPORT;
                        r_scan_idx   <= '0;
                        r_peak_bin   <= w_next_best_bin;
                        r_peak_count <= w_next_best_cnt;
                        r_peak_found <= ({1'b0, w_next_best_cnt} >= LP_MIN_HITS);
                        r_peak_vld   <= 1'b1;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                ST_REPORT: begin
                    r_peak_vld <= 1'b0;
                    r_state    <= ST_ACCUM;
                end
                default: begin
                    r_peak_vld <= 1'b0;
                    r_state    <= ST_ACCUM;
                end
            endcase
        end
    end

    assign peak_bin   = r_peak_bin;
    assign peak_count = r_peak_count;
    assign peak_found = r_peak_found;
    assign peak_vld   = r_peak_vld;

`ifdef LSF_HOUGH_SAT_FLAG_EN
    logic r_sat_evt;
    logic r_sat_flag;
    logic w_sat_hit;

    // A hit landing on a counter one below max (or already at max) means saturation.
    assign w_sat_hit = w_accept_hit && (w_hist[r_bin] >= (LP_CNT_MAX - 1'b1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_evt  <= 1'b0;
            r_sat_flag <= 1'b0;
        end else if (w_scanning) begin
            r_sat_flag <= w_last_scan ? r_sat_evt : 1'b0;
            if (w_last_scan) begin
                r_sat_evt <= 1'b0;
            end
        end else if (w_sat_hit) begin
            r_sat_evt <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`endif

endmodule

// File: tb/tb_hough_bin_accumulator.sv
// Randomized and directed bench for hough_bin_accumulator against an event-level histogram model.
module tb_hough_bin_accumulator;

    localparam int W        = 7;
    localparam int RBINS    = 128;
    localparam int WC       = 5;
    localparam int MIN_HITS = 3;
    localparam int CMAX     = (1 << WC) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  r_bin = '0;
    logic          r_bin_vld = 1'b0;
    logic          evt_end = 1'b0;
    logic          acc_rdy;
    logic [W-1:0]  peak_bin;
    logic [WC-1:0] peak_count;
    logic          peak_found;
    logic          peak_vld;
`ifdef LSF_HOUGH_SAT_FLAG_EN
    logic          sat_flag;
`endif

    always #5 clk = ~clk;

    hough_bin_accumulator #(
        .W_bin_number_a(W),
        .RBINS(RBINS),
        .W_COUNT(WC),
        .MIN_HITS(MIN_HITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .r_bin(r_bin),
        .r_bin_vld(r_bin_vld),
        .evt_end(evt_end),
        .acc_rdy(acc_rdy),
        .peak_bin(peak_bin),
        .peak_count(peak_count),
        .peak_found(peak_found),
        .peak_vld(peak_vld)
`ifdef LSF_HOUGH_SAT_FLAG_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Event-level model: a histogram filled while accepting, and a result due RBINS+1 cycles after evt_end.
    int m_hist[RBINS];
    int m_busy = 0;
    int m_pend_bin, m_pend_cnt;
    bit m_pend_sat;
    int m_pk_bin = 0, m_pk_cnt = 0;
    bit m_pk_found = 0, m_vld = 0, m_sat = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_hist[i]) m_hist[i] = 0;
            m_busy = 0; m_pk_bin = 0; m_pk_cnt = 0; m_pk_found = 0; m_vld = 0; m_sat = 0;
        end else if (m_busy == 0) begin
            m_vld = 0;
            if (r_bin_vld && int'(r_bin) < RBINS && m_hist[r_bin] < CMAX)
                m_hist[r_bin] = m_hist[r_bin] + 1;
            if (evt_end) begin
                m_pend_bin = 0; m_pend_cnt = 0; m_pend_sat = 0;
                for (int i = 0; i < RBINS; i++) begin
                    if (m_hist[i] > m_pend_cnt) begin
                        m_pend_cnt = m_hist[i];
                        m_pend_bin = i;
                    end
                    if (m_hist[i] == CMAX) m_pend_sat = 1;
                    m_hist[i] = 0;
                end
                m_busy = RBINS + 1;
            end
        end else begin
            m_busy = m_busy - 1;
            m_vld = (m_busy == 1);
            if (m_vld) begin
                m_pk_bin = m_pend_bin; m_pk_cnt = m_pend_cnt;
                m_pk_found = (m_pend_cnt >= MIN_HITS); m_sat = m_pend_sat;
            end
        end
        #1;
        check("cyc_acc_rdy", acc_rdy, rst_n && (m_busy == 0));
        check("cyc_peak_vld", peak_vld, m_vld);
        check("cyc_peak_bin", peak_bin, m_pk_bin);
        check("cyc_peak_count", peak_count, m_pk_cnt);
        check("cyc_peak_found", peak_found, m_pk_found);
`ifdef LSF_HOUGH_SAT_FLAG_EN
        if (m_vld) check("cyc_sat_flag", sat_flag, m_sat);
`endif
    end

    // Entries < 0 in hits are idle cycles. abort_at >= 0 pulses reset when that scan index is live.
    task automatic run_event(input int hits[$], input bit end_last, input bit junk, input int abort_at,
                             output logic [31:0] o_bin, output logic [31:0] o_cnt,
                             output logic [31:0] o_found, output logic [31:0] o_sat,
                             output int o_lat, output bit o_seen);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!acc_rdy && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("wait_acc_rdy", acc_rdy, 1);
        foreach (hits[i]) begin
            r_bin_vld = (hits[i] >= 0);
            r_bin     = (hits[i] >= 0) ? W'(hits[i]) : W'($urandom);
            evt_end   = end_last && (i == hits.size() - 1);
            @(negedge clk);
        end
        if (!(end_last && hits.size() > 0)) begin
            r_bin_vld = 1'b0;
            evt_end   = 1'b1;
            @(negedge clk);
        end
        r_bin_vld = 1'b0;
        evt_end   = 1'b0;
        o_lat  = 1;
        o_seen = 0;
        while (o_lat < RBINS + 20) begin
            if (peak_vld) begin
                o_seen = 1;
                break;
            end
            if (abort_at >= 0 && o_lat == abort_at + 1) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if (junk) begin
                r_bin_vld = 1'($urandom_range(0, 1));
                r_bin     = W'($urandom);
                evt_end   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            o_lat++;
        end
        r_bin_vld = 1'b0;
        evt_end   = 1'b0;
        o_bin   = peak_bin;
        o_cnt   = peak_count;
        o_found = peak_found;
`ifdef LSF_HOUGH_SAT_FLAG_EN
        o_sat = sat_flag;
`else
        o_sat = 0;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 0, expected 1 (simulation did not finish)");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int q[$];
        logic [31:0] b, c, f, s;
        int lat;
        bit seen;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_acc_rdy", acc_rdy, 0);
        check("rst_peak_vld", peak_vld, 0);
        check("rst_peak_bin", peak_bin, 0);
        check("rst_peak_count", peak_count, 0);
        check("rst_peak_found", peak_found, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_release", acc_rdy, 1);

        q = {5, 5, 5, 9, 9};
        run_event(q, 0, 0, -1, b, c, f, s, lat, seen);
        check("basic_latency", lat, RBINS + 1);
        check("basic_bin", b, 5);
        check("basic_count", c, 3);
        check("basic_found", f, 1);
`ifdef LSF_HOUGH_SAT_FLAG_EN
        check("basic_sat", s, 0);
`endif

        q = {10, 10, 3, 3};
        run_event(q, 0, 0, -1, b, c, f, s, lat, seen);
        check("tie_bin", b, 3);
        check("tie_count", c, 2);
        check("tie_found", f, 0);

        q.delete();
        for (int k = 0; k < 40; k++) q.push_back(127);
        run_event(q, 0, 0, -1, b, c, f, s, lat, seen);
        check("sat_bin", b, 127);
        check("sat_count", c, 31);
`ifdef LSF_HOUGH_SAT_FLAG_EN
        check("sat_flag", s, 1);
`endif

        q = {7};
        run_event(q, 1, 1, -1, b, c, f, s, lat, seen);
        check("same_cycle_bin", b, 7);
        check("same_cycle_count", c, 1);
        check("same_cycle_latency", lat, RBINS + 1);

        q.delete();
        run_event(q, 0, 0, -1, b, c, f, s, lat, seen);
        check("empty_seen", seen, 1);
        check("empty_bin", b, 0);
        check("empty_count", c, 0);
        check("empty_found", f, 0);

        q = {20, 20, 20, 20};
        run_event(q, 0, 0, 60, b, c, f, s, lat, seen);
        check("abort_no_vld", seen, 0);
        q = {2};
        run_event(q, 0, 0, -1, b, c, f, s, lat, seen);
        check("after_abort_bin", b, 2);
        check("after_abort_count", c, 1);

        for (int e = 0; e < 8; e++) begin
            int base, n, spread;
            base   = $urandom_range(0, RBINS - 8);
            n      = $urandom_range(0, 80);
            spread = (e % 2 == 1) ? 2 : 7;
            q.delete();
            for (int k = 0; k < n; k++)
                q.push_back(($urandom_range(0, 3) == 0) ? -1 : base + $urandom_range(0, spread));
            run_event(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, b, c, f, s, lat, seen);
            check("rand_latency", lat, RBINS + 1);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hough_bin_accumulator.md
HOUGH_BIN_ACCUMULATOR -- requirements
Module: hough_bin_accumulator

Interface
REQ-001 Parameter W_bin_number_a, default 7: r-bin index width.
REQ-002 Parameter RBINS, default 128: number of histogram bins, not greater than 2**W_bin_number_a.
REQ-003 Parameter W_COUNT, default 5: per-bin counter width; counters saturate.
REQ-004 Parameter MIN_HITS, default 3: minimum peak count for a valid segment candidate.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 Port r_bin, input, W_bin_number_a: bin index from the r-bin computation stage.
REQ-008 Port r_bin_vld, input, 1: r_bin qualifier; one hit per asserted cycle.
REQ-009 Port evt_end, input, 1: single-cycle pulse marking the last hit of the event.
REQ-010 Port acc_rdy, output, 1: high only in ACCUM; hits and evt_end are accepted only when high.
REQ-011 Port peak_bin, output, W_bin_number_a: bin with the highest count.
REQ-012 Port peak_count, output, W_COUNT: count of peak_bin.
REQ-013 Port peak_found, output, 1: peak_count >= MIN_HITS; qualified by peak_vld.
REQ-014 Port peak_vld, output, 1: one-cycle result strobe per event.

Function
REQ-015 FSM states ACCUM, SCAN, REPORT; reset state ACCUM.
REQ-016 ACCUM: r_bin_vld=1 with r_bin<RBINS increments hist[r_bin] by 1; new value visible the next cycle.
REQ-017 Increment saturates at 2**W_COUNT-1; no wrap.
REQ-018 r_bin>=RBINS is dropped silently; no counter changes.
REQ-019 Back-to-back hits to the same bin each count; no read-modify-write hazard, no lost increments.
REQ-020 ACCUM to SCAN on evt_end=1; a hit in the same cycle as evt_end is counted before the scan.
REQ-021 SCAN: one bin per cycle, index 0 to RBINS-1; the bin is compared and then cleared to 0 in the same cycle; SCAN lasts exactly RBINS cycles.
REQ-022 Peak compare is strictly greater-than; ties resolve to the lowest index; all-zero histogram gives peak_bin=0, peak_count=0.
REQ-023 After the last SCAN cycle, go to REPORT for 1 cycle: peak_vld=1, peak outputs valid, then return to ACCUM.
REQ-024 Latency: peak_vld asserts RBINS+1 cycles after the evt_end acceptance cycle.
REQ-025 In SCAN and REPORT: acc_rdy=0; r_bin_vld and evt_end are ignored and do not affect the next event.
REQ-026 peak_bin, peak_count and peak_found hold their values until the next REPORT; peak_vld is 0 except in REPORT.
REQ-027 The histogram is all zero on entry to ACCUM.

Reset
REQ-028 While rst_n=0 at a clock edge: state=ACCUM, all hist entries=0, scan index=0, peak_vld=0, peak_bin=0, peak_count=0, peak_found=0.
REQ-029 acc_rdy is driven 0 while rst_n=0, and is 1 on the first cycle after release.
REQ-030 Reset during SCAN or REPORT aborts the event with no peak_vld; the next event starts from a clean histogram.

Configuration
REQ-031 Macro LSF_HOUGH_SAT_FLAG_EN defined: adds output sat_flag (1 bit), valid with peak_vld, set if any bin reached saturation during the event; sat_flag resets to 0 and is cleared in SCAN.
REQ-032 Macro LSF_HOUGH_SAT_FLAG_EN undefined: sat_flag port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-033 Hits to bins 5,5,5,9,9, then evt_end -> peak_vld at evt_end+129 cycles; peak_bin=5, peak_count=3, peak_found=1.
REQ-034 Two hits each to bins 10 and 3 -> peak_bin=3, peak_count=2, peak_found=0 (tie resolves to lowest index).
REQ-035 40 consecutive hits to bin 127 with W_COUNT=5 -> peak_count=31; with the macro defined, sat_flag=1.
REQ-036 Hit to bin 7 driven in the same cycle as evt_end, plus hits driven during SCAN -> the bin-7 hit is counted; SCAN-time hits are absent from this event and the next.
REQ-037 rst_n=0 at scan index 60 -> no peak_vld; a following event with a single hit to bin 2 -> peak_bin=2, peak_count=1.
REQ-038 evt_end with no hits -> peak_bin=0, peak_count=0, peak_found=0, peak_vld asserted once.
